div_unit_64bit: RTL and testbench
=================================

Name: div_unit_64bit

Overview:
- Iterative 64-bit integer divider (restoring, one quotient bit per cycle) for the RISC-V M-extension DIV/DIVU/REM/REMU path.
- Inverse of the 64-bit ripple add/sub datapath: each iteration is one trial subtraction on that adder (Invert_B=1, C_in=1).
- Sits beside the ALU in execute; the pipeline stalls on busy and consumes the result on done.

Parameters:
- WIDTH, 64, operand/result width in bits; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- Is_signed  in  1  1 = DIV/REM two's-complement, 0 = DIVU/REMU.
- Dividend  in  WIDTH  numerator, sampled with start.
- Divisor  in  WIDTH  denominator, sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; results valid this cycle and held afterwards.
- Quotient  out  WIDTH  quotient.
- Remainder  out  WIDTH  remainder.
- Div_by_zero  out  1  flag for the current result.

Behaviour:
- Reset: one clock with reset=1 forces IDLE. busy=0, done=0, Quotient=0, Remainder=0, Div_by_zero=0, iteration counter=0. Reset overrides all other inputs.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=0: stay in IDLE.
- IDLE, start=1, Divisor==0: go to DONE. Quotient=all ones, Remainder=Dividend, Div_by_zero=1.
- IDLE, start=1, signed overflow (Is_signed=1, Dividend=1<<(WIDTH-1), Divisor=all ones): go to DONE. Quotient=Dividend, Remainder=0.
- IDLE, start=1, any other case: go to CALC.
  - Latch abs(Dividend) and abs(Divisor); abs applies only if Is_signed=1.
  - Latch q_neg = sign(Dividend) XOR sign(Divisor) and r_neg = sign(Dividend).
  - Partial remainder = 0; counter = WIDTH.
- CALC, each cycle:
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - Trial diff = rem − divisor, computed with the WIDTH+1-bit adder (invert-B, carry-in 1). Carry-out=1 means no borrow.
  - No borrow: rem = diff, quotient LSB = 1. Borrow: rem unchanged, quotient LSB = 0.
  - Decrement counter; when it reaches 0, go to FIX.
- FIX (1 cycle): negate Quotient if q_neg; negate Remainder if r_neg (signed mode only). Go to DONE.
- DONE (1 cycle): done=1, then go to IDLE. Outputs hold until the next accepted start.
- Latency, with start sampled at cycle 0:
  - Normal op: done at cycle WIDTH+2 (66 for WIDTH=64).
  - Divide-by-zero or signed overflow: done at cycle 1.
- Throughput: start during DONE is ignored. The next start is accepted the cycle after done. start while busy=1 is ignored and operands are not re-sampled.
- Results satisfy Dividend = Quotient·Divisor + Remainder, with sign(Remainder)=sign(Dividend) (truncating division, RISC-V semantics).
- Div_by_zero clears when the next start is accepted.
- Reset during CALC or FIX aborts: IDLE next cycle, no done pulse, outputs zeroed.

Decomposition:
- Shared package div_pkg:
  - div_state_t enum {IDLE, CALC, FIX, DONE}.
  - DIV_WIDTH=64.
  - localparam for the most-negative value.
- One sub-module, div_sign_fix: combinational conditional two's-complement negate, instanced for the operands at IDLE and for the results at FIX.
- The trial subtractor reuses the existing ripple adder, widened by one bit via a 1-bit extension at the top.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 → done only at cycle 66; Quotient=14, Remainder=2, Div_by_zero=0, busy high for cycles 1–66.
- Signed −7 / 2 → Quotient=0xFFFF_FFFF_FFFF_FFFD (−3), Remainder=0xFFFF_FFFF_FFFF_FFFF (−1). Same operands with Is_signed=0 → Quotient=0x7FFF_FFFF_FFFF_FFFC, Remainder=1.
- 5 / 0 (either mode) → done at cycle 1; Quotient=0xFFFF_FFFF_FFFF_FFFF, Remainder=5, Div_by_zero=1. The next normal op clears the flag.
- Signed 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → done at cycle 1; Quotient=0x8000_0000_0000_0000, Remainder=0, Div_by_zero=0.
- Start 1000/3, pulse start again with 9/9 at cycle 20 → second request ignored; result Q=333, R=1 at cycle 66. Start 9/9 at cycle 67 → Q=1, R=0 at cycle 133.
- Start 0xFFFF_FFFF_FFFF_FFFF/1 unsigned, assert reset at cycle 30 → cycle 31 busy=0, outputs 0, no done pulse. A new start at cycle 32 completes correctly with Q=all ones, R=0 at cycle 98.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type, default width and most-negative constant for the divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
  localparam int DIV_WIDTH = 64;
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate (neg -> out_v = -in_v, else out_v = in_v)
module div_sign_fix #(parameter int WIDTH = 64) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in_v,
  output logic [WIDTH-1:0] out_v
);
  assign out_v = neg ? -in_v : in_v;
endmodule

// File: rtl/div_unit_64bit.sv
// div_unit_64bit: restoring divider (clk/reset/start/Is_signed/Dividend/Divisor in; busy/done/Quotient/Remainder/Div_by_zero out)
module div_unit_64bit
  import div_pkg::*;
#(parameter int WIDTH = DIV_WIDTH) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Is_signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  div_state_t state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic q_neg_q, q_neg_d, r_neg_q, r_neg_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [WIDTH:0] trial;
  logic [WIDTH+1:0] diff;
  logic ovf, unused_ok;
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.neg(Is_signed & Dividend[WIDTH-1]), .in_v(Dividend), .out_v(abs_a));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.neg(Is_signed & Divisor[WIDTH-1]), .in_v(Divisor), .out_v(abs_b));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.neg(q_neg_q), .in_v(quo_q), .out_v(q_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.neg(r_neg_q), .in_v(rem_q), .out_v(r_fix));
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff = {1'b0, trial} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH+2)'(1);
  assign unused_ok = diff[WIDTH];
  assign ovf = Is_signed && Dividend == MIN_V && Divisor == '1;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign Quotient = quo_q;
  assign Remainder = rem_q;
  assign Div_by_zero = dbz_q;
  always_comb begin
    state_d = state_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        dbz_d = Divisor == '0;
        if (Divisor == '0) begin
          state_d = DONE;
          quo_d = '1;
          rem_d = Dividend;
        end else if (ovf) begin
          state_d = DONE;
          quo_d = Dividend;
          rem_d = '0;
        end else begin
          state_d = CALC;
          quo_d = abs_a;
          dvs_d = abs_b;
          rem_d = '0;
          cnt_d = CW'(WIDTH);
          q_neg_d = Is_signed & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
          r_neg_d = Is_signed & Dividend[WIDTH-1];
        end
      end
      CALC: begin
        quo_d = {quo_q[WIDTH-2:0], diff[WIDTH+1]};
        rem_d = diff[WIDTH+1] ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? FIX : CALC;
      end
      FIX: begin
        quo_d = q_fix;
        rem_d = r_fix;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_q <= dbz_d;
    end
  end
endmodule

// File: tb/tb_div_unit_64bit.sv
// tb_div_unit_64bit: randomized and directed checks of div_unit_64bit against an arithmetic reference model
module tb_div_unit_64bit;
  import div_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, Is_signed = 1'b0;
  logic [63:0] Dividend = '0, Divisor = '0;
  logic busy, done, Div_by_zero;
  logic [63:0] Quotient, Remainder;
  int chk = 0, pass = 0;
  div_unit_64bit dut (
    .clk(clk), .reset(reset), .start(start), .Is_signed(Is_signed),
    .Dividend(Dividend), .Divisor(Divisor), .busy(busy), .done(done),
    .Quotient(Quotient), .Remainder(Remainder), .Div_by_zero(Div_by_zero)
  );
  always #5 clk = ~clk;
  function automatic void model(input logic [63:0] a, b, input logic s,
                                output logic [63:0] q, r, output logic z, output int lat);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    z = b == 64'd0;
    lat = 66;
    if (b == 64'd0) begin
      q = '1; r = a; lat = 1;
    end else if (s && a == DIV_MIN && b == '1) begin
      q = a; r = '0; lat = 1;
    end else if (s) begin
      q = 64'(sa / sb); r = 64'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
  endfunction
  task automatic run_op(input logic [63:0] a, b, input logic s, input int poke,
                        output int lat, output logic bok);
    Dividend = a; Divisor = b; Is_signed = s; start = 1'b1;
    lat = 0; bok = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!busy) bok = 1'b0;
      start = lat == poke;
      Dividend = lat == poke ? 64'd9 : {$urandom, $urandom};
      Divisor = lat == poke ? 64'd9 : {$urandom, $urandom};
    end while (!done && lat < 200);
    start = 1'b0;
  endtask
  task automatic check_op(input string nm, input logic [63:0] a, b, input logic s, input int lat, input logic bok);
    logic [63:0] eq, er;
    logic ez;
    int el;
    model(a, b, s, eq, er, ez, el);
    chk++; if (lat !== el) $display("FAIL %s latency: got %0d exp %0d", nm, lat, el); else pass++;
    chk++; if (Quotient !== eq) $display("FAIL %s quotient: got %h exp %h", nm, Quotient, eq); else pass++;
    chk++; if (Remainder !== er) $display("FAIL %s remainder: got %h exp %h", nm, Remainder, er); else pass++;
    chk++; if (Div_by_zero !== ez) $display("FAIL %s dbz: got %b exp %b", nm, Div_by_zero, ez); else pass++;
    chk++; if (bok !== 1'b1) $display("FAIL %s busy: got %b exp 1", nm, bok); else pass++;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk++; if ({busy, done, Div_by_zero} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {busy, done, Div_by_zero}); else pass++;
    chk++; if ({Quotient, Remainder} !== 128'd0) $display("FAIL reset_data: got %h exp 0", {Quotient, Remainder}); else pass++;
  endtask
  task automatic test_directed;
    int lat;
    logic bok;
    run_op(64'd100, 64'd7, 1'b0, 0, lat, bok);
    check_op("u100_7", 64'd100, 64'd7, 1'b0, lat, bok);
    chk++; if (Quotient !== 64'd14 || Remainder !== 64'd2) $display("FAIL u100_7_const: got %0d/%0d exp 14/2", Quotient, Remainder); else pass++;
    @(posedge clk); #1;
    chk++; if (done !== 1'b0 || busy !== 1'b0 || Quotient !== 64'd14) $display("FAIL hold: got done=%b busy=%b q=%0d exp 0 0 14", done, busy, Quotient); else pass++;
    run_op(-64'sd7, 64'd2, 1'b1, 0, lat, bok);
    check_op("s_m7_2", -64'sd7, 64'd2, 1'b1, lat, bok);
    chk++; if (Quotient !== 64'hFFFF_FFFF_FFFF_FFFD || Remainder !== '1) $display("FAIL s_m7_2_const: got %h/%h exp -3/-1", Quotient, Remainder); else pass++;
    @(posedge clk); #1;
    run_op(-64'sd7, 64'd2, 1'b0, 0, lat, bok);
    check_op("u_m7_2", -64'sd7, 64'd2, 1'b0, lat, bok);
    chk++; if (Quotient !== 64'h7FFF_FFFF_FFFF_FFFC || Remainder !== 64'd1) $display("FAIL u_m7_2_const: got %h/%h", Quotient, Remainder); else pass++;
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      run_op(64'd5, 64'd0, m[0], 0, lat, bok);
      check_op("div0", 64'd5, 64'd0, m[0], lat, bok);
      @(posedge clk); #1;
    end
    run_op(64'd100, 64'd7, 1'b1, 0, lat, bok);
    check_op("dbz_clear", 64'd100, 64'd7, 1'b1, lat, bok);
    @(posedge clk); #1;
    run_op(DIV_MIN, '1, 1'b1, 0, lat, bok);
    check_op("ovf", DIV_MIN, '1, 1'b1, lat, bok);
    chk++; if (Quotient !== DIV_MIN || Remainder !== 64'd0) $display("FAIL ovf_const: got %h/%h", Quotient, Remainder); else pass++;
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back;
    int lat;
    logic bok;
    run_op(64'd1000, 64'd3, 1'b0, 20, lat, bok);
    check_op("busy_ignore", 64'd1000, 64'd3, 1'b0, lat, bok);
    @(posedge clk); #1;
    run_op(64'd9, 64'd9, 1'b0, 0, lat, bok);
    check_op("after_done", 64'd9, 64'd9, 1'b0, lat, bok);
    @(posedge clk); #1;
  endtask
  task automatic test_reset_abort;
    int lat;
    logic bok;
    logic seen = 1'b0;
    Dividend = '1; Divisor = 64'd1; Is_signed = 1'b0; start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk++; if ({busy, done, seen} !== 3'b000) $display("FAIL abort_flags: got busy=%b done=%b early=%b exp 000", busy, done, seen); else pass++;
    chk++; if ({Quotient, Remainder, Div_by_zero} !== '0) $display("FAIL abort_data: got %h %h %b exp 0", Quotient, Remainder, Div_by_zero); else pass++;
    @(posedge clk); #1;
    run_op('1, 64'd1, 1'b0, 0, lat, bok);
    check_op("post_abort", '1, 64'd1, 1'b0, lat, bok);
    @(posedge clk); #1;
  endtask
  task automatic test_random;
    int lat, k;
    logic bok, s;
    logic [63:0] a, b;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 6);
      s = $urandom_range(0, 1);
      a = {$urandom, $urandom};
      b = k == 0 ? 64'd0 : k == 1 ? 64'($urandom_range(1, 1000)) : k == 2 ? -64'($urandom_range(1, 1000)) :
          k == 3 ? {32'd0, $urandom} : {$urandom, $urandom};
      if (k == 6) begin a = DIV_MIN; b = '1; end
      if (k == 5) a = 64'($urandom_range(0, 50));
      run_op(a, b, s, 0, lat, bok);
      check_op("random", a, b, s, lat, bok);
      if ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      else begin @(posedge clk); #1; @(posedge clk); #1; end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
